// File: rtl/an_tile_encoder_n37_pkg.sv
// Shared constants and types for the A=37 AN-code tile encoder and its
// decoder-side reference model.
package an_n37_pkg;

    localparam int A_CONST  = 37;
    localparam int MSG_W    = 13;
    localparam int CW_W     = 18;
    localparam int TILE_DIM = 6;
    localparam int TILE_N   = TILE_DIM * TILE_DIM;

    localparam logic [MSG_W-1:0] MSG_MAX = 13'd7084;

    typedef logic [CW_W-1:0] cw_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_e;

endpackage

// File: rtl/an_encoder_n37.sv
// Combinational AN encoder: cw = 37*m built from shifts and adds (32+4+1).
// Messages above MSG_MAX produce a zero codeword and raise out_of_range.
module an_encoder_n37
    import an_n37_pkg::*;
(
    input  logic [MSG_W-1:0] msg,
    output cw_t              cw,
    output logic             out_of_range
);

    cw_t msg_ext;
    cw_t cw_raw;

    // Shift-add product; out-of-range inputs are forced to a zero codeword
    always_comb begin
        msg_ext      = CW_W'(msg);
        cw_raw       = (msg_ext << 5) + (msg_ext << 2) + msg_ext;
        out_of_range = (msg > MSG_MAX);
        cw           = out_of_range ? '0 : cw_raw;
    end

endmodule

// File: rtl/an_tile_encoder_n37.sv
// Encodes a message stream into 6x6 tiles of A=37 codewords and presents each
// full tile in parallel, with two ping-pong banks so input can continue while
// a full tile waits downstream.
// Optional build macro AN_TILE_ERR_INJECT_EN adds an output-path error injector.
module an_tile_encoder_n37
    import an_n37_pkg::*;
#(
    parameter int SEQ_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [MSG_W-1:0]       s_msg,
    output logic                   tile_valid,
    input  logic                   tile_ready,
    output logic [TILE_N*CW_W-1:0] tile_cw,
    output logic [SEQ_W-1:0]       tile_seq,
    output logic                   tile_ovf
`ifdef AN_TILE_ERR_INJECT_EN
    ,
    input  logic                   inj_en,
    input  logic [5:0]             inj_idx,
    input  logic [CW_W-1:0]        inj_mask
`endif
);

    cw_t         mem_q   [2][TILE_N];
    cw_t         mem_d   [2][TILE_N];
    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic [1:0]       ovf_q, ovf_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [5:0]       fill_idx_q, fill_idx_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             live_q, live_d;

    cw_t  enc_cw;
    logic enc_oor;
    logic accept;
    logic consume;
    logic rd_full;

    an_encoder_n37 u_enc (
        .msg          (s_msg),
        .cw           (enc_cw),
        .out_of_range (enc_oor)
    );

    // Handshake qualifiers derived purely from registered state
    always_comb begin
        rd_full    = (state_q[rd_bank_q] == FULL);
        s_ready    = live_q && (state_q[wr_bank_q] != FULL);
        tile_valid = rd_full;
        tile_seq   = seq_q;
        tile_ovf   = rd_full && ovf_q[rd_bank_q];
        accept     = s_valid && s_ready;
        consume    = rd_full && tile_ready;
    end

    // Next-state: consume frees the read bank, accept fills the write bank;
    // the two always target different banks so both may act in one cycle
    always_comb begin
        mem_d      = mem_q;
        state_d    = state_q;
        ovf_d      = ovf_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        fill_idx_d = fill_idx_q;
        seq_d      = seq_q;
        live_d     = 1'b1;
        if (consume) begin
            state_d[rd_bank_q] = EMPTY;
            ovf_d[rd_bank_q]   = 1'b0;
            rd_bank_d          = ~rd_bank_q;
            seq_d              = seq_q + SEQ_W'(1);
        end
        if (accept) begin
            mem_d[wr_bank_q][fill_idx_q] = enc_cw;
            if (enc_oor) begin
                ovf_d[wr_bank_q] = 1'b1;
            end
            if (fill_idx_q == 6'(TILE_N - 1)) begin
                state_d[wr_bank_q] = FULL;
                fill_idx_d         = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILLING;
                fill_idx_d         = fill_idx_q + 6'd1;
            end
        end
    end

    // State registers; reset discards both banks including any held tile
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                for (int k = 0; k < TILE_N; k++) begin
                    mem_q[b][k] <= '0;
                end
            end
            ovf_q      <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            fill_idx_q <= '0;
            seq_q      <= '0;
            live_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            fill_idx_q <= fill_idx_d;
            seq_q      <= seq_d;
            live_q     <= live_d;
        end
    end

    // Present the read bank; the optional injector flips bits on the way out only
    always_comb begin
        tile_cw = '0;
        for (int k = 0; k < TILE_N; k++) begin
`ifdef AN_TILE_ERR_INJECT_EN
            if (inj_en && (inj_idx == 6'(k))) begin
                tile_cw[k*CW_W +: CW_W] = mem_q[rd_bank_q][k] ^ inj_mask;
            end else begin
                tile_cw[k*CW_W +: CW_W] = mem_q[rd_bank_q][k];
            end
`else
            tile_cw[k*CW_W +: CW_W] = mem_q[rd_bank_q][k];
`endif
        end
    end

endmodule

// File: tb/tb_an_tile_encoder_n37.sv
// Directed self-checking bench for an_tile_encoder_n37.
// Define AN_TILE_ERR_INJECT_EN for both RTL and bench to cover the injector.
module tb_an_tile_encoder_n37;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [12:0]  s_msg;
    logic         tile_valid;
    logic         tile_ready;
    logic [647:0] tile_cw;
    logic [7:0]   tile_seq;
    logic         tile_ovf;
`ifdef AN_TILE_ERR_INJECT_EN
    logic         inj_en;
    logic [5:0]   inj_idx;
    logic [17:0]  inj_mask;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    an_tile_encoder_n37 #(.SEQ_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_msg      (s_msg),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_cw    (tile_cw),
        .tile_seq   (tile_seq),
        .tile_ovf   (tile_ovf)
`ifdef AN_TILE_ERR_INJECT_EN
        ,
        .inj_en     (inj_en),
        .inj_idx    (inj_idx),
        .inj_mask   (inj_mask)
`endif
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [17:0] slot(input int k);
        return tile_cw[k*18 +: 18];
    endfunction

    task automatic do_reset;
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_msg      = '0;
        tile_ready = 1'b0;
`ifdef AN_TILE_ERR_INJECT_EN
        inj_en     = 1'b0;
        inj_idx    = '0;
        inj_mask   = '0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [12:0] m);
        int waited;
        bit done;
        waited  = 0;
        done    = 1'b0;
        s_valid = 1'b1;
        s_msg   = m;
        while (!done) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL send_beat: s_ready stuck at 0, required 1 within 200 cycles");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_msg = '0; tile_ready = 1'b0;
`ifdef AN_TILE_ERR_INJECT_EN
        inj_en = 1'b0; inj_idx = '0; inj_mask = '0;
`endif
        @(posedge clk); @(negedge clk);
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_s_ready: got %b want 0", s_ready); end
        n_tests++; if (tile_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tile_valid: got %b want 0", tile_valid); end
        n_tests++; if (tile_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_tile_seq: got %0d want 0", tile_seq); end
        n_tests++; if (tile_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tile_ovf: got %b want 0", tile_ovf); end
        n_tests++; if (tile_cw !== 648'd0) begin n_fail++; $display("[TB] FAIL reset_tile_cw: nonzero, want 0"); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_s_ready: got %b want 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_tile;
        do_reset();
        tile_ready = 1'b1;
        for (int k = 0; k < 35; k++) send_beat(13'(k));
        s_valid = 1'b1; s_msg = 13'd35;
        @(negedge clk);
        n_tests++; if (tile_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid: got %b want 0", tile_valid); end
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (tile_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_latency: tile_valid got %b want 1", tile_valid); end
        n_tests++; if (tile_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL basic_seq0: got %0d want 0", tile_seq); end
        n_tests++; if (tile_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovf: got %b want 0", tile_ovf); end
        for (int k = 0; k < 36; k++) begin
            n_tests++;
            if (slot(k) !== 18'(37 * k)) begin
                n_fail++; $display("[TB] FAIL basic_slot%0d: got %0d want %0d", k, slot(k), 37 * k);
            end
        end
        @(posedge clk); @(negedge clk);
        n_tests++; if (tile_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_consumed: tile_valid got %b want 0", tile_valid); end
        n_tests++; if (tile_seq !== 8'd1) begin n_fail++; $display("[TB] FAIL basic_seq1: got %0d want 1", tile_seq); end
        tile_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_range;
        do_reset();
        send_beat(13'd7084);
        send_beat(13'd7085);
        for (int k = 2; k < 36; k++) send_beat(13'(k));
        s_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (tile_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL range_valid: got %b want 1", tile_valid); end
        n_tests++; if (slot(0) !== 18'd262108) begin n_fail++; $display("[TB] FAIL range_slot0: got %0d want 262108", slot(0)); end
        n_tests++; if (slot(1) !== 18'd0) begin n_fail++; $display("[TB] FAIL range_slot1: got %0d want 0", slot(1)); end
        n_tests++; if (slot(2) !== 18'd74) begin n_fail++; $display("[TB] FAIL range_slot2: got %0d want 74", slot(2)); end
        n_tests++; if (tile_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL range_ovf: got %b want 1", tile_ovf); end
        @(posedge clk); #1;
        tile_ready = 1'b1;
        @(posedge clk); #1;
        tile_ready = 1'b0;
        for (int k = 0; k < 36; k++) send_beat(13'(k + 7000));
        s_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (tile_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL range_clean_valid: got %b want 1", tile_valid); end
        n_tests++; if (tile_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL range_clean_ovf: got %b want 0", tile_ovf); end
        n_tests++; if (slot(35) !== 18'd260295) begin n_fail++; $display("[TB] FAIL range_clean_slot35: got %0d want 260295", slot(35)); end
        n_tests++; if (tile_seq !== 8'd1) begin n_fail++; $display("[TB] FAIL range_clean_seq: got %0d want 1", tile_seq); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int beat;
        int stall_at;
        beat = 0; stall_at = -1;
        do_reset();
        for (int c = 0; c < 90; c++) begin
            s_valid = (beat < 80);
            s_msg   = 13'(beat);
            @(negedge clk);
            if (!s_ready && stall_at < 0) stall_at = beat;
            if (s_valid && s_ready) beat++;
            @(posedge clk); #1;
        end
        n_tests++; if (stall_at !== 72) begin n_fail++; $display("[TB] FAIL bp_stall_point: stalled after %0d accepts want 72", stall_at); end
        n_tests++; if (beat !== 72) begin n_fail++; $display("[TB] FAIL bp_accept_count: got %0d want 72", beat); end
        @(negedge clk);
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_s_ready_low: got %b want 0", s_ready); end
        n_tests++; if (tile_valid !== 1'b1 || tile_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL bp_hold_tile0: valid %b seq %0d want 1/0", tile_valid, tile_seq); end
        n_tests++; if (slot(5) !== 18'd185 || slot(35) !== 18'd1295) begin n_fail++; $display("[TB] FAIL bp_hold_data: slot5 %0d slot35 %0d want 185/1295", slot(5), slot(35)); end
        @(posedge clk); #1;
        tile_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (tile_valid !== 1'b1 || tile_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL bp_release_t0: valid %b seq %0d want 1/0", tile_valid, tile_seq); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (tile_valid !== 1'b1 || tile_seq !== 8'd1) begin n_fail++; $display("[TB] FAIL bp_release_t1: valid %b seq %0d want 1/1", tile_valid, tile_seq); end
        n_tests++; if (slot(0) !== 18'd1332) begin n_fail++; $display("[TB] FAIL bp_t1_slot0: got %0d want 1332", slot(0)); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_s_ready_return: got %b want 1", s_ready); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (tile_valid !== 1'b0 || tile_seq !== 8'd2) begin n_fail++; $display("[TB] FAIL bp_drained: valid %b seq %0d want 0/2", tile_valid, tile_seq); end
        @(posedge clk); #1;
        s_valid = 1'b0; tile_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int beat;
        bit exp_valid;
        int exp_t;
        beat = 0;
        do_reset();
        tile_ready = 1'b1;
        for (int c = 0; c < 111; c++) begin
            s_valid = (beat < 108);
            s_msg   = 13'(beat);
            @(negedge clk);
            exp_valid = (c == 36) || (c == 72) || (c == 108);
            exp_t     = c / 36 - 1;
            if (s_valid) begin
                n_tests++;
                if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_s_ready c%0d: got %b want 1", c, s_ready); end
            end
            n_tests++;
            if (tile_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL b2b_valid c%0d: got %b want %b", c, tile_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (tile_seq !== 8'(exp_t) || slot(0) !== 18'(37 * 36 * exp_t) || slot(35) !== 18'(37 * (36 * exp_t + 35))) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_tile%0d: seq %0d slot0 %0d slot35 %0d want %0d/%0d/%0d", exp_t, tile_seq, slot(0), slot(35),
                             exp_t, 37 * 36 * exp_t, 37 * (36 * exp_t + 35));
                end
            end
            if (s_valid && s_ready) beat++;
            @(posedge clk); #1;
        end
        n_tests++; if (beat !== 108) begin n_fail++; $display("[TB] FAIL b2b_beats: got %0d want 108", beat); end
        s_valid = 1'b0; tile_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        do_reset();
        tile_ready = 1'b1;
        for (int k = 0; k < 20; k++) send_beat(13'(k));
        s_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (slot(1) !== 18'd37) begin n_fail++; $display("[TB] FAIL midrst_partial: slot1 %0d want 37", slot(1)); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (s_ready !== 1'b0 || tile_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_handshake: s_ready %b tile_valid %b want 0/0", s_ready, tile_valid); end
        n_tests++; if (tile_cw !== 648'd0 || tile_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_outputs: tile_cw nonzero or seq %0d, want 0", tile_seq); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tile_ready = 1'b0;
        for (int k = 0; k < 36; k++) send_beat(13'(100 + k));
        s_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (tile_valid !== 1'b1 || tile_seq !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_tile: valid %b seq %0d want 1/0", tile_valid, tile_seq); end
        n_tests++; if (slot(0) !== 18'd3700 || slot(35) !== 18'd4995) begin n_fail++; $display("[TB] FAIL midrst_data: slot0 %0d slot35 %0d want 3700/4995", slot(0), slot(35)); end
        @(posedge clk); #1;
    endtask

`ifdef AN_TILE_ERR_INJECT_EN
    task automatic test_inject;
        do_reset();
        for (int k = 0; k < 36; k++) send_beat(13'(k));
        s_valid  = 1'b0;
        inj_en   = 1'b1;
        inj_idx  = 6'd14;
        inj_mask = 18'h00001;
        @(negedge clk);
        n_tests++; if (slot(14) !== 18'd519) begin n_fail++; $display("[TB] FAIL inj_slot14: got %0d want 519", slot(14)); end
        n_tests++; if (slot(13) !== 18'd481 || slot(15) !== 18'd555) begin n_fail++; $display("[TB] FAIL inj_neighbours: %0d/%0d want 481/555", slot(13), slot(15)); end
        inj_idx = 6'd40;
        #1;
        for (int k = 0; k < 36; k++) begin
            n_tests++;
            if (slot(k) !== 18'(37 * k)) begin n_fail++; $display("[TB] FAIL inj_ignored_slot%0d: got %0d want %0d", k, slot(k), 37 * k); end
        end
        inj_en = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    // Scenario sequence followed by the single summary line
    initial begin
        test_reset();
        test_basic_tile();
        test_range();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef AN_TILE_ERR_INJECT_EN
        test_inject();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
